// File: rtl/load_ext_pkg.sv
// Shared definitions for the load-extension pipe: size codes, held-entry
// layout and the occupancy states of the two-entry output buffer.
package load_ext_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Entries are sized for the widest legal build; narrower builds ignore the top bits.
  localparam int DATA_MAX = 64;
  localparam int TAG_MAX  = 16;

  typedef struct packed {
    logic [DATA_MAX-1:0] data;
    logic [TAG_MAX-1:0]  tag;
    logic                misalign;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_t;

endpackage

// File: rtl/load_ext_lane.sv
// Combinational lane select plus sign/zero extension of a memory read word.
// LOAD_EXT_MISALIGN_CHK_EN: flag misaligned offsets and zero the result
// instead of rounding the offset down to the access alignment.
module load_ext_lane
  import load_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  result_o,
  output logic             misalign_o
);

  logic [1:0]       eff_size;
  logic [OFF_W-1:0] align_mask;
  logic [OFF_W-1:0] off_eff;
  logic [XLEN-1:0]  lane;
  logic [XLEN-1:0]  keep;
  logic [XLEN-1:0]  ext;
  logic             sbit;

  always_comb begin
    eff_size = size_i;
    if (XLEN == 32 && size_i == SZ_D) eff_size = SZ_W;

    case (eff_size)
      SZ_H:    align_mask = OFF_W'(1);
      SZ_W:    align_mask = OFF_W'(3);
      SZ_D:    align_mask = OFF_W'(7);
      default: align_mask = '0;
    endcase

    misalign_o = |(off_i & align_mask);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    off_eff = off_i;
`else
    off_eff = off_i & ~align_mask;
`endif

    lane = data_i >> {off_eff, 3'b000};

    // Bits outside the kept lane are refilled from the lane MSB, or zeroed.
    case (eff_size)
      SZ_B: begin
        keep = XLEN'(8'hFF);
        sbit = lane[7];
      end
      SZ_H: begin
        keep = XLEN'(16'hFFFF);
        sbit = lane[15];
      end
      SZ_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sbit = lane[31];
      end
      default: begin
        keep = '1;
        sbit = lane[XLEN-1];
      end
    endcase

    ext = (lane & keep) | ({XLEN{sbit & ~unsigned_i}} & ~keep);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    result_o = misalign_o ? '0 : ext;
`else
    result_o = ext;
`endif
  end

endmodule

// File: rtl/load_ext_pipe.sv
// Registered load-extension stage with valid/ready handshake and a skid entry.
// LOAD_EXT_MISALIGN_CHK_EN adds the out_misalign port and pipelines the flag.
module load_ext_pipe
  import load_ext_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  TAG_W = 5,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic [OFF_W-1:0] in_off,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef LOAD_EXT_MISALIGN_CHK_EN
  ,
  output logic             out_misalign
`endif
);

  occ_t            state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          new_entry;
  logic            in_ready_q;
  logic            accept, retire;
  logic [XLEN-1:0] lane_data;
  logic            lane_mis;
  logic            unused_bits;

  load_ext_lane #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_lane (
    .data_i     (in_data),
    .off_i      (in_off),
    .size_i     (in_size),
    .unsigned_i (in_unsigned),
    .result_o   (lane_data),
    .misalign_o (lane_mis)
  );

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign retire    = out_valid & out_ready;

  always_comb begin
    new_entry      = '0;
    new_entry.data = DATA_MAX'(lane_data);
    new_entry.tag  = TAG_MAX'(in_tag);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    new_entry.misalign = lane_mis;
`else
    new_entry.misalign = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_d   = new_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            out_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign out_data = out_q.data[XLEN-1:0];
  assign out_tag  = out_q.tag[TAG_W-1:0];
`ifdef LOAD_EXT_MISALIGN_CHK_EN
  assign out_misalign = out_q.misalign;
`endif

  assign unused_bits = ^{out_q, lane_mis};

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: one XLEN=32 and one XLEN=64 instance,
// directed cases followed by randomized traffic with backpressure and flushes.
module tb_load_ext_pipe;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    bit          mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;

  logic        inValid32, inReady32, inUns32, outValid32, outReady32, outMis32;
  logic [31:0] inData32, outData32;
  logic [1:0]  inOff32, inSize32;
  logic [4:0]  inTag32, outTag32;

  logic        inValid64, inReady64, inUns64, outValid64, outReady64, outMis64;
  logic [63:0] inData64, outData64;
  logic [2:0]  inOff64;
  logic [1:0]  inSize64;
  logic [4:0]  inTag64, outTag64;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  load_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (inValid32),
    .in_ready    (inReady32),
    .in_data     (inData32),
    .in_off      (inOff32),
    .in_size     (inSize32),
    .in_unsigned (inUns32),
    .in_tag      (inTag32),
    .out_valid   (outValid32),
    .out_ready   (outReady32),
    .out_data    (outData32),
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    .out_misalign(outMis32),
`endif
    .out_tag     (outTag32)
  );

  load_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (inValid64),
    .in_ready    (inReady64),
    .in_data     (inData64),
    .in_off      (inOff64),
    .in_size     (inSize64),
    .in_unsigned (inUns64),
    .in_tag      (inTag64),
    .out_valid   (outValid64),
    .out_ready   (outReady64),
    .out_data    (outData64),
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    .out_misalign(outMis64),
`endif
    .out_tag     (outTag64)
  );

`ifndef LOAD_EXT_MISALIGN_CHK_EN
  assign outMis32 = 1'b0;
  assign outMis64 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the access's bytes by arithmetic, then widen by the lane's top bit.
  function automatic exp_t modelLoad(int xlen, logic [63:0] data, int off, int size,
                                     bit uns, logic [4:0] tag);
    exp_t        r;
    int          sz;
    int          nbytes;
    int          nbits;
    int          offE;
    logic [63:0] v;
    logic [63:0] lowMask;
    sz = size;
    if (xlen == 32 && sz == 3) sz = 2;
    nbytes = 1 << sz;
    nbits  = 8 * nbytes;
    r.tag  = tag;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    r.mis = (off % nbytes) != 0;
    offE  = off;
    if (r.mis) begin
      r.data = 64'h0;
      return r;
    end
`else
    r.mis = 1'b0;
    offE  = off - (off % nbytes);
`endif
    v = data >> (8 * offE);
    if (nbits < 64) begin
      lowMask = (64'd1 << nbits) - 64'd1;
      v = v & lowMask;
      if (!uns && v[nbits-1]) v = v | ~lowMask;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    r.data = v;
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [31:0] d, logic [1:0] off, logic [1:0] sz, logic uns,
                               logic [4:0] tag);
    inValid32 = 1'b1;
    inData32  = d;
    inOff32   = off;
    inSize32  = sz;
    inUns32   = uns;
    inTag32   = tag;
    tick();
    inValid32 = 1'b0;
  endtask

  task automatic applyStimulus64(logic [63:0] d, logic [2:0] off, logic [1:0] sz, logic uns,
                                 logic [4:0] tag);
    inValid64 = 1'b1;
    inData64  = d;
    inOff64   = off;
    inSize64  = sz;
    inUns64   = uns;
    inTag64   = tag;
    tick();
    inValid64 = 1'b0;
  endtask

  task automatic directed32(string name, logic [31:0] d, logic [1:0] off, logic [1:0] sz,
                            logic uns, logic [31:0] expData, logic expMis);
    applyStimulus(d, off, sz, uns, 5'd9);
    @(negedge clk);
    checkOutput({name, "_valid"}, outValid32, 1);
    checkOutput(name, outData32, expData);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    checkOutput({name, "_mis"}, outMis32, expMis);
`else
    if (expMis) $display("[TB] note: %s expects no misalign port in this build", name);
`endif
    tick();
  endtask

  task automatic directed64(string name, logic [63:0] d, logic [2:0] off, logic [1:0] sz,
                            logic uns, logic [63:0] expData);
    applyStimulus64(d, off, sz, uns, 5'd17);
    @(negedge clk);
    checkOutput({name, "_valid"}, outValid64, 1);
    checkOutput(name, outData64, expData);
    tick();
  endtask

  // Expected results are queued when a beat is accepted; a flush that same edge wins.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (inValid32 && inReady32)
        q32.push_back(modelLoad(32, {32'h0, inData32}, int'(inOff32), int'(inSize32),
                                inUns32, inTag32));
      if (inValid64 && inReady64)
        q64.push_back(modelLoad(64, inData64, int'(inOff64), int'(inSize64),
                                inUns64, inTag64));
    end
  end

  // Monitor retires results against the queue head, then applies any flush.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (outValid32 && outReady32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra32: out_valid=1 tag=%0d, expected no result", outTag32);
        end else begin
          e = q32.pop_front();
          checkOutput("sb_data32", {32'h0, outData32}, e.data);
          checkOutput("sb_tag32", {59'h0, outTag32}, {59'h0, e.tag});
`ifdef LOAD_EXT_MISALIGN_CHK_EN
          checkOutput("sb_mis32", {63'h0, outMis32}, {63'h0, e.mis});
`endif
        end
      end
      if (outValid64 && outReady64) begin
        if (q64.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra64: out_valid=1 tag=%0d, expected no result", outTag64);
        end else begin
          e = q64.pop_front();
          checkOutput("sb_data64", outData64, e.data);
          checkOutput("sb_tag64", {59'h0, outTag64}, {59'h0, e.tag});
`ifdef LOAD_EXT_MISALIGN_CHK_EN
          checkOutput("sb_mis64", {63'h0, outMis64}, {63'h0, e.mis});
`endif
        end
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit done;
    rst = 1'b1;
    flush = 1'b0;
    inValid32 = 0; inData32 = 0; inOff32 = 0; inSize32 = 0; inUns32 = 0; inTag32 = 0;
    inValid64 = 0; inData64 = 0; inOff64 = 0; inSize64 = 0; inUns64 = 0; inTag64 = 0;
    outReady32 = 1'b1;
    outReady64 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid32", outValid32, 0);
    checkOutput("rst_data32", outData32, 0);
    checkOutput("rst_tag32", outTag32, 0);
    checkOutput("rst_mis32", outMis32, 0);
    checkOutput("rst_valid64", outValid64, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("rst_ready32", inReady32, 1);
    checkOutput("rst_ready64", inReady64, 1);

    directed32("byte_off1", 32'h80F1_7F22, 2'd1, 2'b00, 1'b0, 32'h0000_007F, 1'b0);
    directed32("byte_off3", 32'h80F1_7F22, 2'd3, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
    directed32("half_off2_u", 32'h80F1_7F22, 2'd2, 2'b01, 1'b1, 32'h0000_80F1, 1'b0);
    directed32("dword_as_word", 32'h80F1_7F22, 2'd0, 2'b11, 1'b0, 32'h80F1_7F22, 1'b0);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    directed32("half_off1_mis", 32'h80F1_7F22, 2'd1, 2'b01, 1'b0, 32'h0, 1'b1);
`else
    directed32("half_off1_round", 32'h80F1_7F22, 2'd1, 2'b01, 1'b0, 32'h0000_7F22, 1'b0);
`endif
    directed64("word_off4", 64'h8000_0000_1234_5678, 3'd4, 2'b10, 1'b0, 64'hFFFF_FFFF_8000_0000);
    directed64("dword_off0", 64'h8000_0000_1234_5678, 3'd0, 2'b11, 1'b0, 64'h8000_0000_1234_5678);
    directed64("half_off6_u", 64'h8000_0000_1234_5678, 3'd6, 2'b01, 1'b1, 64'h0000_0000_0000_8000);

    // Backpressure: two beats fill the buffer, the third waits for space.
    outReady32 = 1'b0;
    applyStimulus(32'h11, 2'd0, 2'b10, 1'b0, 5'd1);
    applyStimulus(32'h22, 2'd0, 2'b10, 1'b0, 5'd2);
    inValid32 = 1'b1;
    inData32 = 32'h33;
    inTag32 = 5'd3;
    @(negedge clk);
    checkOutput("bp_ready_low", inReady32, 0);
    checkOutput("bp_hold_tag", outTag32, 1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("bp_still_low", inReady32, 0);
    checkOutput("bp_stable_tag", outTag32, 1);
    checkOutput("bp_stable_data", outData32, 32'h11);
    tick();
    outReady32 = 1'b1;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (inReady32) done = 1;
      tick();
    end
    inValid32 = 1'b0;
    checkOutput("bp_tag3_accepted", done, 1);
    repeat (4) tick();
    checkOutput("bp_drained", outValid32, 0);

    // Flush while full, with a new beat offered in the same cycle.
    outReady32 = 1'b0;
    applyStimulus(32'hAA, 2'd0, 2'b00, 1'b0, 5'd4);
    applyStimulus(32'hBB, 2'd0, 2'b00, 1'b0, 5'd5);
    flush = 1'b1;
    inValid32 = 1'b1;
    inTag32 = 5'd6;
    tick();
    flush = 1'b0;
    inValid32 = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", outValid32, 0);
    checkOutput("flush_ready", inReady32, 1);
    tick();
    outReady32 = 1'b1;
    repeat (4) tick();

    // Asynchronous reset between edges while a result is held.
    outReady32 = 1'b0;
    applyStimulus(32'hCAFE_F00D, 2'd0, 2'b10, 1'b0, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", outValid32, 0);
    checkOutput("arst_data", outData32, 0);
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("arst_ready", inReady32, 1);
    checkOutput("arst_valid_after", outValid32, 0);
    outReady32 = 1'b1;

    for (int i = 0; i < 400; i++) begin
      inValid32  = ($urandom_range(0, 3) != 0);
      inData32   = $urandom;
      inOff32    = 2'($urandom_range(0, 3));
      inSize32   = 2'($urandom_range(0, 3));
      inUns32    = 1'($urandom_range(0, 1));
      inTag32    = 5'($urandom_range(0, 31));
      outReady32 = ($urandom_range(0, 3) != 0);
      inValid64  = ($urandom_range(0, 3) != 0);
      inData64   = {$urandom, $urandom};
      inOff64    = 3'($urandom_range(0, 7));
      inSize64   = 2'($urandom_range(0, 3));
      inUns64    = 1'($urandom_range(0, 1));
      inTag64    = 5'($urandom_range(0, 31));
      outReady64 = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      tick();
    end
    inValid32 = 1'b0;
    inValid64 = 1'b0;
    flush = 1'b0;
    outReady32 = 1'b1;
    outReady64 = 1'b1;
    for (int k = 0; k < 20 && (q32.size() != 0 || q64.size() != 0); k++) tick();
    tick();
    checkOutput("drain_q32", q32.size(), 0);
    checkOutput("drain_q64", q64.size(), 0);
    checkOutput("drain_valid32", outValid32, 0);
    checkOutput("drain_valid64", outValid64, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
